seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the team's 4-bit combinational ALU. It accepts one operation at a time over a valid/ready handshake and executes it. Single-step ops finish in 1 cycle. Shifts take one cycle per bit position. Optional multiply is iterative shift-add. The result is held with flags until the consumer accepts it. It sits between an operand/command source and a result sink in the datapath.

---
 rtl/seq_alu.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle ALU with valid/ready handshake. Define SEQ_ALU_MUL_EN
//            to enable the iterative shift-add multiply on opcode 1001.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] C_OP_ADD = 4'b0000;
   localparam logic [3:0] C_OP_SUB = 4'b0001;
   localparam logic [3:0] C_OP_AND = 4'b0010;
   localparam logic [3:0] C_OP_OR  = 4'b0011;
   localparam logic [3:0] C_OP_XOR = 4'b0100;
   localparam logic [3:0] C_OP_NOT = 4'b0101;
   localparam logic [3:0] C_OP_SHL = 4'b0110;
   localparam logic [3:0] C_OP_SHR = 4'b0111;
   localparam logic [3:0] C_OP_ASR = 4'b1000;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [3:0] C_OP_MUL = 4'b1001;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [3:0]        r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_amt_zero;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_init;
   logic              w_last;
   logic              w_is_shift;

   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_val;
   logic [WIDTH-1:0]  w_hi;
   logic              w_c;
   logic              w_v;
   logic              w_err;

`ifdef SEQ_ALU_MUL_EN
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic [WIDTH:0]     w_madd;
`endif

   assign w_last     = (r_cnt == CW'(1));
   assign w_is_shift = (r_op == C_OP_SHL) || (r_op == C_OP_SHR) || (r_op == C_OP_ASR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = EXEC;
         end
         EXEC: if (w_last) w_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Shift by zero still costs one cycle, so the count never starts at 0.
   always_comb begin
      w_cnt_init = CW'(1);
      if ((op == C_OP_SHL) || (op == C_OP_SHR) || (op == C_OP_ASR)) begin
         if (b[SHW-1:0] != '0) w_cnt_init = {1'b0, b[SHW-1:0]};
      end
`ifdef SEQ_ALU_MUL_EN
      else if (op == C_OP_MUL) begin
         w_cnt_init = CW'(WIDTH);
      end
`endif
   end

   always_comb begin
      w_sum = '0;
      w_val = r_a;
      w_hi  = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_err = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      w_madd     = '0;
      w_prod_nxt = r_prod;
`endif
      case (r_op)
         C_OP_ADD: begin
            w_sum = {1'b0, r_a} + {1'b0, r_b};
            w_val = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         C_OP_SUB: begin
            w_sum = {1'b0, r_a} - {1'b0, r_b};
            w_val = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         C_OP_AND: w_val = r_a & r_b;
         C_OP_OR:  w_val = r_a | r_b;
         C_OP_XOR: w_val = r_a ^ r_b;
         C_OP_NOT: w_val = ~r_a;
         C_OP_SHL: if (!r_amt_zero) begin
            w_val = {r_a[WIDTH-2:0], 1'b0};
            w_c   = r_a[WIDTH-1];
         end
         C_OP_SHR: if (!r_amt_zero) begin
            w_val = {1'b0, r_a[WIDTH-1:1]};
            w_c   = r_a[0];
         end
         C_OP_ASR: if (!r_amt_zero) begin
            w_val = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            w_c   = r_a[0];
         end
`ifdef SEQ_ALU_MUL_EN
         // Multiplier lives in the low half of r_prod and is consumed LSB first.
         C_OP_MUL: begin
            w_madd     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
            w_prod_nxt = {w_madd, r_prod[WIDTH-1:1]};
            w_val      = w_prod_nxt[WIDTH-1:0];
            w_hi       = w_prod_nxt[2*WIDTH-1:WIDTH];
            w_c        = |w_hi;
         end
`endif
         default: begin
            w_val = '0;
            w_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_amt_zero <= 1'b0;
         r_cnt      <= '0;
`ifdef SEQ_ALU_MUL_EN
         r_prod     <= '0;
`endif
         result     <= '0;
         result_hi  <= '0;
         carry      <= 1'b0;
         zero       <= 1'b0;
         negative   <= 1'b0;
         overflow   <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_op       <= op;
               r_a        <= a;
               r_b        <= b;
               r_amt_zero <= (b[SHW-1:0] == '0);
               r_cnt      <= w_cnt_init;
`ifdef SEQ_ALU_MUL_EN
               r_prod     <= {{WIDTH{1'b0}}, b};
`endif
            end
            EXEC: begin
               r_cnt <= r_cnt - CW'(1);
               if (w_is_shift) r_a <= w_val;
`ifdef SEQ_ALU_MUL_EN
               r_prod <= w_prod_nxt;
`endif
               if (w_last) begin
                  result    <= w_val;
                  result_hi <= w_hi;
                  carry     <= w_c;
                  zero      <= ({w_hi, w_val} == '0);
                  negative  <= w_val[WIDTH-1];
                  overflow  <= w_v;
                  err       <= w_err;
               end
            end
            DONE: if (out_ready) begin
               result    <= '0;
               result_hi <= '0;
               carry     <= 1'b0;
               zero      <= 1'b0;
               negative  <= 1'b0;
               overflow  <= 1'b0;
               err       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Scoreboard bench for seq_alu (WIDTH=8), both SEQ_ALU_MUL_EN builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         c;
      logic         z;
      logic         n;
      logic         v;
      logic         e;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         carry;
   logic         zero;
   logic         negative;
   logic         overflow;
   logic         err;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .carry     (carry),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] res, input logic [W-1:0] hi,
                               input logic c, input logic z, input logic n,
                               input logic v, input logic e);
      return {res, hi, c, z, n, v, e};
   endfunction

   // Monitor: every accepted result is popped and compared.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: actual=%0h expected=none", result);
         end else begin
            mon_e = sb_q.pop_front();
            chk("result",    result,    mon_e.res);
            chk("result_hi", result_hi, mon_e.hi);
            chk("carry",     carry,     mon_e.c);
            chk("zero",      zero,      mon_e.z);
            chk("negative",  negative,  mon_e.n);
            chk("overflow",  overflow,  mon_e.v);
            chk("err",       err,       mon_e.e);
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input exp_t e, input int lat, input bit push);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a  = aa;
      b  = bb;
      if (push) sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = ~o;
      a  = ~aa;
      b  = ~bb;
      n  = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, lat);
      if (out_ready && out_valid) begin
         @(posedge clk);
         #1;
         chk("idle_out_valid", out_valid, 0);
         chk("idle_in_ready",  in_ready,  1);
         chk("idle_result",    result,    0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 4'h0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result",    result,    0);
      chk("rst_result_hi", result_hi, 0);
      chk("rst_flags", {carry, zero, negative, overflow, err}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Arithmetic and logic
      issue(4'h0, 8'hF0, 8'h20, mk(8'h10, 8'h00, 1, 0, 0, 0, 0), 1, 1);
      issue(4'h1, 8'h03, 8'h05, mk(8'hFE, 8'h00, 1, 0, 1, 0, 0), 1, 1);
      issue(4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 0, 1, 1, 0), 1, 1);
      issue(4'h1, 8'h80, 8'h01, mk(8'h7F, 8'h00, 0, 0, 0, 1, 0), 1, 1);
      issue(4'h1, 8'h05, 8'h05, mk(8'h00, 8'h00, 0, 1, 0, 0, 0), 1, 1);
      issue(4'h2, 8'h0F, 8'h3C, mk(8'h0C, 8'h00, 0, 0, 0, 0, 0), 1, 1);
      issue(4'h3, 8'h0F, 8'h30, mk(8'h3F, 8'h00, 0, 0, 0, 0, 0), 1, 1);
      issue(4'h5, 8'h55, 8'h00, mk(8'hAA, 8'h00, 0, 0, 1, 0, 0), 1, 1);

      // Shifts
      issue(4'h6, 8'hC1, 8'h02, mk(8'h04, 8'h00, 1, 0, 0, 0, 0), 2, 1);
      issue(4'h8, 8'h90, 8'h03, mk(8'hF2, 8'h00, 0, 0, 1, 0, 0), 3, 1);
      issue(4'h7, 8'h81, 8'h00, mk(8'h81, 8'h00, 0, 0, 1, 0, 0), 1, 1);
      issue(4'h6, 8'h01, 8'h07, mk(8'h80, 8'h00, 0, 0, 1, 0, 0), 7, 1);
      issue(4'h7, 8'h03, 8'h09, mk(8'h01, 8'h00, 1, 0, 0, 0, 0), 1, 1);

      // Multiply and illegal opcodes
`ifdef SEQ_ALU_MUL_EN
      issue(4'h9, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 1, 0, 0, 0, 0), 8, 1);
      issue(4'h9, 8'h0C, 8'h0A, mk(8'h78, 8'h00, 0, 0, 0, 0, 0), 8, 1);
`else
      issue(4'h9, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 0, 1, 0, 0, 1), 1, 1);
      issue(4'h9, 8'h0C, 8'h0A, mk(8'h00, 8'h00, 0, 1, 0, 0, 1), 1, 1);
`endif
      issue(4'hF, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 0, 1, 0, 0, 1), 1, 1);
      issue(4'hA, 8'h12, 8'h34, mk(8'h00, 8'h00, 0, 1, 0, 0, 1), 1, 1);

      // Backpressure: result held, new commands ignored, no accept on exit edge
      out_ready = 1'b0;
      issue(4'h4, 8'h5A, 8'hFF, mk(8'hA5, 8'h00, 0, 0, 1, 0, 0), 1, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op = 4'h0;
         a  = 8'h11;
         b  = 8'h22;
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready",  in_ready,  0);
         chk("bp_result",    result,    8'hA5);
         chk("bp_negative",  negative,  1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_out_valid", out_valid, 0);
      chk("bp_release_in_ready",  in_ready,  1);
      chk("bp_release_result",    result,    0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_no_accept", in_ready, 1);

      // Reset while holding a result
      out_ready = 1'b0;
      issue(4'h2, 8'h0F, 8'h3C, mk(8'h0C, 8'h00, 0, 0, 0, 0, 0), 1, 0);
      chk("hold_result", result, 8'h0C);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_done_out_valid", out_valid, 0);
      chk("rst_done_in_ready",  in_ready,  1);
      chk("rst_done_result",    result,    0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Reset part-way through a long operation
      @(negedge clk);
      in_valid = 1'b1;
`ifdef SEQ_ALU_MUL_EN
      op = 4'h9;
      a  = 8'hFF;
      b  = 8'hFF;
`else
      op = 4'h6;
      a  = 8'h01;
      b  = 8'h07;
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_exec_in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_exec_in_ready",  in_ready,  1);
      chk("rst_exec_out_valid", out_valid, 0);
      chk("rst_exec_result",    result,    0);
      chk("rst_exec_result_hi", result_hi, 0);
      chk("rst_exec_flags", {carry, zero, negative, overflow, err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(4'h0, 8'h01, 8'h01, mk(8'h02, 8'h00, 0, 0, 0, 0, 0), 1, 1);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: actual=%0d pending expected=0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
